// File: rtl/idma_pkg.sv
// Shared types and constants for the iDMA burst scheduler.
package idma_pkg;

  localparam int unsigned BEAT_SHIFT = 5;
  localparam int unsigned AXLEN_W    = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sched_st_e;

  // AXLEN for the next burst: min(max_len, remaining-1); remaining is never 0 here.
  function automatic logic [AXLEN_W-1:0] burst_len(input logic [AXLEN_W-1:0] max_len,
                                                  input logic [15:0]         remaining);
    logic [15:0] last;
    last = remaining - 16'd1;
    if (last < 16'(max_len)) begin
      return last[AXLEN_W-1:0];
    end
    return max_len;
  endfunction

endpackage

// File: rtl/idma_ostd_cnt.sv
// Saturating up/down counter of logical bursts in flight.
module idma_ostd_cnt #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         underflow_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == W'(MAX));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: if (!full_o) cnt_d = cnt_q + W'(1);
      2'b01: begin
        if (empty_o) underflow_o = 1'b1;
        else         cnt_d       = cnt_q - W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/idma_burst_sched.sv
// Splits one DMA descriptor into logical bursts of up to 16 x 32-byte beats,
// caps bursts in flight and signals completion once every data phase is done.
module idma_burst_sched
  import idma_pkg::*;
#(
  parameter int unsigned MAX_OSTD = 4,
  parameter int unsigned OSTD_W   = 4
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               cfg_start_valid,
  output logic               cfg_start_ready,
  input  logic [31:0]        cfg_addr,
  input  logic [15:0]        cfg_beats,
  input  logic [AXLEN_W-1:0] cfg_max_len,
  input  logic               cfg_abort,
  output logic               dma_trans_burst_avalid,
  output logic [31:0]        dma_trans_burst_addr,
  output logic [AXLEN_W-1:0] dma_trans_burst_len,
  input  logic               dma_xaddr_burst_ok,
  input  logic               burst_data_done,
  output logic               sched_busy,
  output logic               sched_done,
  output logic               sched_err
);

  sched_st_e          state_q, state_d;
  logic               avalid_q, avalid_d;
  logic [31:0]        addr_q, addr_d;
  logic [AXLEN_W-1:0] len_q, len_d;
  logic [AXLEN_W-1:0] max_len_q, max_len_d;
  logic [15:0]        rem_q, rem_d;
  logic               err_q, err_d;

  logic               ostd_inc, ostd_full, ostd_empty, ostd_underflow;
  logic [OSTD_W-1:0]  ostd_cnt;
  logic [AXLEN_W:0]   acc_beats;

  // An ok without a pending request is not a real acceptance.
  assign ostd_inc  = dma_xaddr_burst_ok & avalid_q;
  assign acc_beats = {1'b0, len_q} + (AXLEN_W+1)'(1);

  idma_ostd_cnt #(
    .MAX (MAX_OSTD),
    .W   (OSTD_W)
  ) u_ostd_cnt (
    .clk_i       (aclk),
    .rst_i       (areset),
    .inc_i       (ostd_inc),
    .dec_i       (burst_data_done),
    .cnt_o       (ostd_cnt),
    .full_o      (ostd_full),
    .empty_o     (ostd_empty),
    .underflow_o (ostd_underflow)
  );

  always_comb begin
    state_d         = state_q;
    avalid_d        = avalid_q;
    addr_d          = addr_q;
    len_d           = len_q;
    max_len_d       = max_len_q;
    rem_d           = rem_q;
    err_d           = err_q | ostd_underflow;
    cfg_start_ready = (state_q == IDLE);
    sched_done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start_valid) begin
          addr_d    = {cfg_addr[31:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
          rem_d     = cfg_beats;
          max_len_d = cfg_max_len;
          if (cfg_beats != 16'd0) begin
            state_d = ISSUE;
            if (!ostd_full) begin
              len_d    = burst_len(cfg_max_len, cfg_beats);
              avalid_d = 1'b1;
            end
          end else begin
            state_d = DRAIN;
          end
        end
      end
      ISSUE: begin
        if (avalid_q) begin
          // A held request is always finished, even under abort or a full cap.
          if (dma_xaddr_burst_ok) begin
            avalid_d = 1'b0;
            addr_d   = addr_q + (32'(acc_beats) << BEAT_SHIFT);
            rem_d    = rem_q - 16'(acc_beats);
            if (rem_d == 16'd0 || cfg_abort) state_d = DRAIN;
          end
        end else if (cfg_abort) begin
          state_d = DRAIN;
        end else if (!ostd_full) begin
          len_d    = burst_len(max_len_q, rem_q);
          avalid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (ostd_empty) begin
          sched_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      avalid_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      max_len_q <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      avalid_q  <= avalid_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      max_len_q <= max_len_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
    end
  end

  assign dma_trans_burst_avalid = avalid_q;
  assign dma_trans_burst_addr   = addr_q;
  assign dma_trans_burst_len    = len_q;
  assign sched_busy             = (state_q != IDLE);
  assign sched_err              = err_q;

endmodule

// File: tb/tb_idma_burst_sched.sv
// Directed bench for idma_burst_sched with a two-burst outstanding cap.
module tb_idma_burst_sched;

  logic        clk = 1'b0;
  logic        areset;
  logic        valid, ready;
  logic [31:0] addr;
  logic [15:0] beats;
  logic [3:0]  maxlen;
  logic        abort;
  logic        avalid;
  logic [31:0] baddr;
  logic [3:0]  blen;
  logic        ok, dd;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idma_burst_sched #(
    .MAX_OSTD (2),
    .OSTD_W   (4)
  ) dut (
    .aclk                   (clk),
    .areset                 (areset),
    .cfg_start_valid        (valid),
    .cfg_start_ready        (ready),
    .cfg_addr               (addr),
    .cfg_beats              (beats),
    .cfg_max_len            (maxlen),
    .cfg_abort              (abort),
    .dma_trans_burst_avalid (avalid),
    .dma_trans_burst_addr   (baddr),
    .dma_trans_burst_len    (blen),
    .dma_xaddr_burst_ok     (ok),
    .burst_data_done        (dd),
    .sched_busy             (busy),
    .sched_done             (done),
    .sched_err              (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] b, input logic [3:0] m);
    chk("start_ready", 32'(ready), 32'd1);
    valid  = 1'b1;
    addr   = a;
    beats  = b;
    maxlen = m;
    step();
    valid  = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] ea, input logic [3:0] el);
    int n = 0;
    while (avalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_avalid"}, 32'(avalid), 32'd1);
    chk({tag, "_addr"}, baddr, ea);
    chk({tag, "_len"}, 32'(blen), 32'(el));
  endtask

  // Accept the held request; afterwards avalid must have dropped.
  task automatic give_ok(input string tag);
    ok = 1'b1;
    step();
    ok = 1'b0;
    chk({tag, "_drop"}, 32'(avalid), 32'd0);
  endtask

  task automatic give_dd();
    dd = 1'b1;
    step();
    dd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; valid = 1'b0; addr = '0; beats = '0; maxlen = '0;
    abort = 1'b0; ok = 1'b0; dd = 1'b0;
    step();
    step();
    chk("rst_avalid", 32'(avalid), 32'd0);
    chk("rst_addr", baddr, 32'd0);
    chk("rst_len", 32'(blen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    areset = 1'b0;
    step();

    // 40 beats from 0x1000_0000: 16 + 16 + 8, cap of two in flight
    start(32'h1000_0000, 16'd40, 4'd15);
    chk("t1_first_avalid", 32'(avalid), 32'd1);
    chk("t1_first_addr", baddr, 32'h1000_0000);
    chk("t1_first_len", 32'(blen), 32'd15);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_low", 32'(ready), 32'd0);
    step();
    chk("t1_hold_avalid", 32'(avalid), 32'd1);
    give_ok("t1_b1");
    wait_req("t1_b2", 32'h1000_0200, 4'd15);
    give_ok("t1_b2");
    step(); step(); step();
    chk("t1_cap_avalid", 32'(avalid), 32'd0);
    give_dd();
    wait_req("t1_b3", 32'h1000_0400, 4'd7);
    give_ok("t1_b3");
    chk("t1_drain_done", 32'(done), 32'd0);
    chk("t1_drain_busy", 32'(busy), 32'd1);
    give_dd();
    chk("t1_one_left_done", 32'(done), 32'd0);
    give_dd();
    chk("t1_done", 32'(done), 32'd1);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_ready", 32'(ready), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // Empty transfer
    start(32'h0000_1000, 16'd0, 4'd15);
    chk("t3_avalid", 32'(avalid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_done", 32'(done), 32'd1);
    step();
    chk("t3_done_pulse", 32'(done), 32'd0);
    chk("t3_busy_low", 32'(busy), 32'd0);

    // Single-beat bursts across the top of the address space; low bits dropped
    start(32'hFFFF_FFF7, 16'd2, 4'd0);
    chk("t4_b1_addr", baddr, 32'hFFFF_FFE0);
    chk("t4_b1_len", 32'(blen), 32'd0);
    give_ok("t4_b1");
    wait_req("t4_b2", 32'h0000_0000, 4'd0);
    give_ok("t4_b2");
    give_dd();
    give_dd();
    chk("t4_done", 32'(done), 32'd1);
    step();

    // Abort while a request is held and ok is late
    start(32'h2000_0000, 16'd64, 4'd15);
    abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_avalid", 32'(avalid), 32'd1);
      chk("t5_hold_addr", baddr, 32'h2000_0000);
      chk("t5_hold_len", 32'(blen), 32'd15);
    end
    give_ok("t5");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_more_avalid", 32'(avalid), 32'd0);
    end
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_not_done", 32'(done), 32'd0);
    give_dd();
    chk("t5_done", 32'(done), 32'd1);
    abort = 1'b0;
    step();
    chk("t5_idle", 32'(busy), 32'd0);

    // ok and data_done together at one outstanding burst
    start(32'h3000_0000, 16'd32, 4'd15);
    chk("t6_b1_addr", baddr, 32'h3000_0000);
    give_ok("t6_b1");
    wait_req("t6_b2", 32'h3000_0200, 4'd15);
    ok = 1'b1;
    dd = 1'b1;
    step();
    ok = 1'b0;
    dd = 1'b0;
    chk("t6_still_one_a", 32'(done), 32'd0);
    step();
    chk("t6_still_one_b", 32'(done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    give_dd();
    chk("t6_done", 32'(done), 32'd1);
    step();

    // Stray data_done sets a sticky error that only reset clears
    chk("t6_err_clear", 32'(err), 32'd0);
    give_dd();
    chk("t6_err_set", 32'(err), 32'd1);
    step(); step(); step();
    chk("t6_err_sticky", 32'(err), 32'd1);
    start(32'h4000_0000, 16'd40, 4'd15);
    chk("t6_issue_avalid", 32'(avalid), 32'd1);
    chk("t6_err_in_issue", 32'(err), 32'd1);
    areset = 1'b1;
    step();
    chk("t6_rst_avalid", 32'(avalid), 32'd0);
    chk("t6_rst_ready", 32'(ready), 32'd1);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_addr", baddr, 32'd0);
    areset = 1'b0;
    step();
    chk("t6_post_avalid", 32'(avalid), 32'd0);
    chk("t6_post_ready", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
